// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and ecall-halt tracking
module id_ex_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned HALT_CODE = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_is_ecall,
  input  logic [1:0]        id_alu_op,
  input  logic [3:0]        id_funct,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_x17_data,
  output logic              stall,
  output logic              halted,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_is_ecall,
  output logic [1:0]        ex_alu_op,
  output logic [3:0]        ex_funct,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_halt
);

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic              is_ecall;
    logic              halt;
    logic [1:0]        alu_op;
    logic [3:0]        funct;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
  } ex_t;

  ex_t               ex_q, ex_d;
  logic              halted_q, halted_d;
  logic [REG_AW-1:0] rs1_eff;
  logic              use1_eff;
  logic              hazard;
  logic              bubble;

  // ecall implicitly reads x17 to decide whether it halts
  assign rs1_eff  = id_is_ecall ? REG_AW'(17) : id_rs1;
  assign use1_eff = id_is_ecall | id_use_rs1;

  assign hazard = (use1_eff & (rs1_eff == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd));
  assign stall  = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                  ~flush & ~halted_q & hazard;
  assign bubble = flush | halted_q | stall | ~id_valid;

  always_comb begin
    ex_d     = '0;
    halted_d = halted_q | (ex_q.valid & ex_q.halt);
    if (!bubble) begin
      ex_d.valid      = 1'b1;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.mem_write  = id_mem_write;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_write  = id_reg_write & (id_rd != '0);
      ex_d.is_ecall   = id_is_ecall;
      ex_d.halt       = id_is_ecall & (id_x17_data == XLEN'(HALT_CODE));
      ex_d.alu_op     = id_alu_op;
      ex_d.funct      = id_funct;
      ex_d.rs1        = id_rs1;
      ex_d.rs2        = id_rs2;
      ex_d.rd         = id_rd;
      ex_d.rs1_data   = id_rs1_data;
      ex_d.rs2_data   = id_rs2_data;
      ex_d.imm        = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      halted_q <= halted_d;
    end
  end

  assign halted        = halted_q;
  assign ex_valid      = ex_q.valid;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_is_ecall   = ex_q.is_ecall;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_funct      = ex_q.funct;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_halt       = ex_q.halt;

endmodule
